// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and 8N1 frame constants.
// No logic; types and constants only.
// Used by both the transmit and receive paths.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  localparam int DATA_BITS = 8;
  localparam int BIT_W     = $clog2(DATA_BITS);
  // Wide enough for the largest legal CLKS_PER_BIT (65535).
  localparam int CNT_W     = 16;

endpackage

// File: rtl/uart_rx.sv
// UART 8N1 receiver with 2-flop input synchroniser and mid-bit sampling.
// Latency: byte valid the cycle after the stop bit is sampled (about 9.5 bit times after the start edge plus sync delay).
// Backpressure: none on the line; an unconsumed byte is overwritten by the next good frame (overrun).
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  input  logic                 ready,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid
);

  localparam logic [CNT_W-1:0] LAST    = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF    = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BIT_W-1:0] LAST_BT = BIT_W'(DATA_BITS - 1);

  state_e               state, state_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt;
  logic [BIT_W-1:0]     bit_idx, bit_nxt;
  logic [DATA_BITS-1:0] sh, sh_nxt;
  logic [DATA_BITS-1:0] data_nxt;
  logic                 valid_nxt;
  logic                 wait_hi, wait_nxt;
  logic                 s1, s2, prev;
  logic                 load;

  // Synchronise the asynchronous line and keep one cycle of history for edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1   <= 1'b1;
      s2   <= 1'b1;
      prev <= 1'b1;
    end else begin
      s1   <= rx;
      s2   <= s1;
      prev <= s2;
    end
  end

  // Receiver state and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      sh      <= '0;
      wait_hi <= 1'b0;
      data    <= '0;
      valid   <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bit_idx <= bit_nxt;
      sh      <= sh_nxt;
      wait_hi <= wait_nxt;
      data    <= data_nxt;
      valid   <= valid_nxt;
    end
  end

  // Next-state logic; after a framing error STOP parks until the line returns high
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    bit_nxt   = bit_idx;
    sh_nxt    = sh;
    wait_nxt  = wait_hi;
    load      = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt  = '0;
        bit_nxt  = '0;
        wait_nxt = 1'b0;
        if (prev && !s2) state_nxt = START;
      end
      START: begin
        if (cnt == HALF) begin
          cnt_nxt   = '0;
          state_nxt = s2 ? IDLE : DATA;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      DATA: begin
        if (cnt == LAST) begin
          cnt_nxt = '0;
          sh_nxt  = {s2, sh[DATA_BITS-1:1]};
          if (bit_idx == LAST_BT) begin
            bit_nxt   = '0;
            state_nxt = STOP;
          end else begin
            bit_nxt = bit_idx + 1'b1;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      STOP: begin
        if (wait_hi) begin
          if (s2) begin
            wait_nxt  = 1'b0;
            state_nxt = IDLE;
          end
        end else if (cnt == LAST) begin
          cnt_nxt = '0;
          if (s2) begin
            load      = 1'b1;
            state_nxt = IDLE;
          end else begin
            wait_nxt = 1'b1;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output handshake: a completing frame wins over a same-cycle consume
  always_comb begin
    data_nxt  = data;
    valid_nxt = valid;
    if (load) begin
      data_nxt  = sh;
      valid_nxt = 1'b1;
    end else if (valid && ready) begin
      valid_nxt = 1'b0;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART 8N1 transmitter: serialises one byte per frame, LSB first.
// Latency: line goes low the cycle after acceptance; ready returns 10*CLKS_PER_BIT cycles later.
// Backpressure: ready is high only in IDLE; the byte is captured at acceptance and input changes are ignored until then.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] data,
  input  logic                 valid,
  output logic                 ready,
  output logic                 tx
);

  localparam logic [CNT_W-1:0] LAST    = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] LAST_BT = BIT_W'(DATA_BITS - 1);

  state_e               state, state_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt;
  logic [BIT_W-1:0]     bit_idx, bit_nxt;
  logic [DATA_BITS-1:0] sh, sh_nxt;
  logic                 tx_nxt;
  logic                 live;
  logic                 bit_done;

  // ready is held low during reset and only rises once the first clock edge after release has been seen
  assign ready    = live && (state == IDLE);
  assign bit_done = (cnt == LAST);

  // State, counters, shift register and registered line output
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      sh      <= '0;
      tx      <= 1'b1;
      live    <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bit_idx <= bit_nxt;
      sh      <= sh_nxt;
      tx      <= tx_nxt;
      live    <= 1'b1;
    end
  end

  // Next-state and next line value; each state holds for CLKS_PER_BIT cycles
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    bit_nxt   = bit_idx;
    sh_nxt    = sh;
    tx_nxt    = tx;
    case (state)
      IDLE: begin
        tx_nxt  = 1'b1;
        cnt_nxt = '0;
        bit_nxt = '0;
        if (valid && ready) begin
          state_nxt = START;
          sh_nxt    = data;
          tx_nxt    = 1'b0;
        end
      end
      START: begin
        if (bit_done) begin
          cnt_nxt   = '0;
          state_nxt = DATA;
          tx_nxt    = sh[0];
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      DATA: begin
        if (bit_done) begin
          cnt_nxt = '0;
          if (bit_idx == LAST_BT) begin
            state_nxt = STOP;
            bit_nxt   = '0;
            tx_nxt    = 1'b1;
          end else begin
            bit_nxt = bit_idx + 1'b1;
            sh_nxt  = {1'b0, sh[DATA_BITS-1:1]};
            tx_nxt  = sh[1];
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      STOP: begin
        if (bit_done) begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: rtl/uart_tx_rx.sv
// UART 8N1 transceiver: independent transmitter and receiver sharing one bit rate.
// Latency: see uart_tx / uart_rx; the two paths do not interact.
// Backpressure: tx_out__ready gates byte acceptance; the receive side overwrites on overrun.
module uart_tx_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_in__data,
  input  logic                 tx_in__valid,
  output logic                 tx_out__ready,
  output logic                 tx_out__tx,
  input  logic                 rx_in__rx,
  input  logic                 rx_in__ready,
  output logic [DATA_BITS-1:0] rx_out__data,
  output logic                 rx_out__valid
);

  uart_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
    .clk   (clk),
    .rst   (rst),
    .data  (tx_in__data),
    .valid (tx_in__valid),
    .ready (tx_out__ready),
    .tx    (tx_out__tx)
  );

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk   (clk),
    .rst   (rst),
    .rx    (rx_in__rx),
    .ready (rx_in__ready),
    .data  (rx_out__data),
    .valid (rx_out__valid)
  );

endmodule

// File: tb/tb_uart_tx_rx.sv
// Directed bench for uart_tx_rx: reset, TX framing, loopback, RX error cases, overrun, mid-frame reset.
// Latency: expectations are counted in clock cycles from the acceptance edge.
// Backpressure: rx_in__ready is driven per scenario; received bytes are logged on each consume.
module tb_uart_tx_rx;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       tx_line;
  logic       rx_ready = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       loop = 1'b1;
  logic       rx_drv = 1'b1;
  logic       rx_line;
  logic       done = 1'b0;

  int checks = 0;
  int errors = 0;
  logic [7:0] rxq[$];

  assign rx_line = loop ? tx_line : rx_drv;

  always #5 clk = ~clk;

  uart_tx_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk           (clk),
    .rst           (rst),
    .tx_in__data   (tx_data),
    .tx_in__valid  (tx_valid),
    .tx_out__ready (tx_ready),
    .tx_out__tx    (tx_line),
    .rx_in__rx     (rx_line),
    .rx_in__ready  (rx_ready),
    .rx_out__data  (rx_data),
    .rx_out__valid (rx_valid)
  );

  // Log every byte the consumer takes
  always @(posedge clk) begin
    if (rst && rx_valid && rx_ready) rxq.push_back(rx_data);
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [8:0] pop_rx();
    if (rxq.size() == 0) return 9'h000;
    return {1'b1, rxq.pop_front()};
  endfunction

  task automatic tx_send(input logic [7:0] b);
    int n = 0;
    while (tx_ready !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (tx_ready !== 1'b1) begin
      errors++;
      $display("FAIL tx_send_wait: ready=%b required 1", tx_ready);
    end
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic wait_tx_idle();
    int n = 0;
    while (tx_ready !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (tx_ready !== 1'b1) begin
      errors++;
      $display("FAIL tx_idle_wait: ready=%b required 1", tx_ready);
    end
  endtask

  task automatic rx_frame(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx_drv = f[i];
      repeat (CPB) @(negedge clk);
    end
    rx_drv = 1'b1;
    repeat (40) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (tx_line !== 1'b1)    begin errors++; $display("FAIL reset_tx: got %b required 1", tx_line); end
    checks++; if (tx_ready !== 1'b0)   begin errors++; $display("FAIL reset_ready: got %b required 0", tx_ready); end
    checks++; if (rx_valid !== 1'b0)   begin errors++; $display("FAIL reset_valid: got %b required 0", rx_valid); end
    checks++; if (rx_data !== 8'h00)   begin errors++; $display("FAIL reset_data: got %h required 00", rx_data); end
    rst = 1'b1;
    #1;
    checks++; if (tx_ready !== 1'b0)   begin errors++; $display("FAIL release_ready_pre_edge: got %b required 0", tx_ready); end
    @(posedge clk); #1;
    checks++; if (tx_ready !== 1'b1)   begin errors++; $display("FAIL release_ready_first_edge: got %b required 1", tx_ready); end
  endtask

  task automatic test_tx_a5();
    logic [9:0] exp_line;
    logic [8:0] got;
    int bad_line = 0;
    int bad_rdy = 0;
    exp_line = 10'b11_0100_1010;
    loop = 1'b1;
    @(negedge clk);
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL a5_ready_before: got %b required 1", tx_ready); end
    tx_data  = 8'hA5;
    tx_valid = 1'b1;
    @(posedge clk); #1;
    tx_valid = 1'b0;
    checks++; if (tx_line !== 1'b0)  begin errors++; $display("FAIL a5_start_low: got %b required 0", tx_line); end
    checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL a5_ready_falls: got %b required 0", tx_ready); end
    for (int n = 1; n <= 160; n++) begin
      @(posedge clk); #1;
      if (n < 160) begin
        if (tx_line !== exp_line[n / CPB]) bad_line++;
        if (tx_ready !== 1'b0) bad_rdy++;
      end
    end
    checks++; if (bad_line != 0) begin errors++; $display("FAIL a5_line: %0d wrong cycles, required 0", bad_line); end
    checks++; if (bad_rdy != 0)  begin errors++; $display("FAIL a5_ready_low: %0d early-ready cycles, required 0", bad_rdy); end
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL a5_ready_at_160: got %b required 1", tx_ready); end
    checks++; if (tx_line !== 1'b1)  begin errors++; $display("FAIL a5_idle_line: got %b required 1", tx_line); end
    repeat (5) @(negedge clk);
    got = pop_rx();
    checks++; if (got !== 9'h1A5) begin errors++; $display("FAIL a5_loopback: got %h required 1a5", got); end
  endtask

  task automatic test_hold_valid();
    logic [7:0] rebuilt;
    logic [8:0] got;
    int bad_rdy = 0;
    rebuilt = 8'h00;
    @(negedge clk);
    tx_data  = 8'h3A;
    tx_valid = 1'b1;
    @(posedge clk); #1;
    tx_data = 8'($urandom);
    for (int n = 1; n <= 161; n++) begin
      @(posedge clk); #1;
      if (n % CPB == CPB / 2 && n / CPB >= 1 && n / CPB <= 8) rebuilt[n / CPB - 1] = tx_line;
      if (n < 160 && tx_ready !== 1'b0) bad_rdy++;
      if (n == 160) begin
        checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL hold_ready_at_160: got %b required 1", tx_ready); end
      end
      if (n == 161) begin
        checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL hold_second_accept_ready: got %b required 0", tx_ready); end
        checks++; if (tx_line !== 1'b0)  begin errors++; $display("FAIL hold_second_accept_line: got %b required 0", tx_line); end
        tx_valid = 1'b0;
      end
      if (n < 160) tx_data = 8'($urandom);
      else if (n == 160) tx_data = 8'hC3;
    end
    checks++; if (bad_rdy != 0)     begin errors++; $display("FAIL hold_ready_low: %0d early-ready cycles, required 0", bad_rdy); end
    checks++; if (rebuilt !== 8'h3A) begin errors++; $display("FAIL hold_frame_byte: got %h required 3a", rebuilt); end
    wait_tx_idle();
    repeat (5) @(negedge clk);
    got = pop_rx();
    checks++; if (got !== 9'h13A) begin errors++; $display("FAIL hold_rx_first: got %h required 13a", got); end
    got = pop_rx();
    checks++; if (got !== 9'h1C3) begin errors++; $display("FAIL hold_rx_second: got %h required 1c3", got); end
  endtask

  task automatic test_loopback();
    logic [8:0] got;
    int n;
    loop = 1'b1;
    done = 1'b0;
    rxq.delete();
    fork
      begin
        while (!done) begin
          rx_ready = ~rx_ready;
          repeat ($urandom_range(0, 399)) @(negedge clk);
        end
      end
      begin
        for (int i = 0; i <= 10; i++) begin
          tx_send(8'(i));
          n = 0;
          while (rxq.size() < i + 1 && n < 3000) begin
            @(negedge clk);
            n++;
          end
          checks++;
          if (rxq.size() < i + 1) begin
            errors++;
            $display("FAIL loop_wait_byte_%0d: received %0d required %0d", i, rxq.size(), i + 1);
          end
        end
        done = 1'b1;
      end
    join
    @(negedge clk);
    rx_ready = 1'b1;
    repeat (400) @(negedge clk);
    checks++; if (rxq.size() != 11) begin errors++; $display("FAIL loop_count: got %0d required 11", rxq.size()); end
    for (int i = 0; i <= 10; i++) begin
      got = pop_rx();
      checks++;
      if (got !== {1'b1, 8'(i)}) begin
        errors++;
        $display("FAIL loop_byte_%0d: got %h required %h", i, got, {1'b1, 8'(i)});
      end
    end
  endtask

  task automatic test_frame_error();
    logic [8:0] got;
    loop   = 1'b0;
    rx_drv = 1'b1;
    rxq.delete();
    repeat (20) @(negedge clk);
    rx_frame(8'h3C, 1'b0);
    checks++; if (rxq.size() != 0) begin errors++; $display("FAIL ferr_no_byte: got %0d bytes required 0", rxq.size()); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL ferr_valid: got %b required 0", rx_valid); end
    rx_frame(8'h3C, 1'b1);
    got = pop_rx();
    checks++; if (got !== 9'h13C) begin errors++; $display("FAIL ferr_recover: got %h required 13c", got); end
  endtask

  task automatic test_glitch();
    logic [8:0] got;
    loop   = 1'b0;
    rx_drv = 1'b0;
    repeat (CPB / 4) @(negedge clk);
    rx_drv = 1'b1;
    repeat (200) @(negedge clk);
    checks++; if (rxq.size() != 0)   begin errors++; $display("FAIL glitch_no_byte: got %0d bytes required 0", rxq.size()); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL glitch_valid: got %b required 0", rx_valid); end
    rx_frame(8'h96, 1'b1);
    got = pop_rx();
    checks++; if (got !== 9'h196) begin errors++; $display("FAIL glitch_recover: got %h required 196", got); end
  endtask

  task automatic test_overrun();
    logic [8:0] got;
    loop = 1'b0;
    @(negedge clk);
    rx_ready = 1'b0;
    rx_frame(8'h11, 1'b1);
    checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL ovr_first_valid: got %b required 1", rx_valid); end
    checks++; if (rx_data !== 8'h11) begin errors++; $display("FAIL ovr_first_data: got %h required 11", rx_data); end
    rx_frame(8'h22, 1'b1);
    checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL ovr_second_valid: got %b required 1", rx_valid); end
    checks++; if (rx_data !== 8'h22) begin errors++; $display("FAIL ovr_second_data: got %h required 22", rx_data); end
    rx_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL ovr_consume: got %b required 0", rx_valid); end
    got = pop_rx();
    checks++; if (got !== 9'h122) begin errors++; $display("FAIL ovr_taken: got %h required 122", got); end
    checks++; if (rxq.size() != 0) begin errors++; $display("FAIL ovr_extra: got %0d bytes required 0", rxq.size()); end
  endtask

  task automatic test_reset_midframe();
    logic [8:0] got;
    loop = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    tx_send(8'h77);
    wait_tx_idle();
    repeat (5) @(negedge clk);
    checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL mrst_pre_valid: got %b required 1", rx_valid); end
    checks++; if (rx_data !== 8'h77) begin errors++; $display("FAIL mrst_pre_data: got %h required 77", rx_data); end
    tx_send(8'hEE);
    repeat (80) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (tx_line !== 1'b1)  begin errors++; $display("FAIL mrst_tx: got %b required 1", tx_line); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL mrst_valid: got %b required 0", rx_valid); end
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL mrst_data: got %h required 00", rx_data); end
    checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL mrst_ready: got %b required 0", tx_ready); end
    repeat (3) @(negedge clk);
    rst      = 1'b1;
    rx_ready = 1'b1;
    repeat (300) @(negedge clk);
    checks++; if (rxq.size() != 0) begin errors++; $display("FAIL mrst_no_partial: got %0d bytes required 0", rxq.size()); end
    tx_send(8'h55);
    wait_tx_idle();
    repeat (5) @(negedge clk);
    got = pop_rx();
    checks++; if (got !== 9'h155) begin errors++; $display("FAIL mrst_roundtrip: got %h required 155", got); end
  endtask

  initial begin
    test_reset();
    test_tx_a5();
    test_hold_valid();
    test_loopback();
    test_frame_error();
    test_glitch();
    test_overrun();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
